// File: rtl/uart_rx_frame_ctrl.sv
// uart_rx_frame_ctrl: frame controller behind a UART receiver.
// Hunts for SYNC_BYTE, parses ID / LEN / payload (/ CHK), buffers the
// payload and holds a verified frame for the host (valid/ready plus a
// registered random-access read port). Bad, oversized or stalled frames
// are dropped and reported on o_Err / o_Err_Code.
//
// Build option: define UART_FRAME_CHECKSUM_EN to include the trailing
// checksum byte (8-bit sum of ID, LEN and payload) and its verification.
// Without it the frame ends after the last payload byte.

module uart_rx_frame_ctrl #(
    parameter int         ADDR_W       = 4,
    parameter int         TIMEOUT_CLKS = 100000,
    parameter logic [7:0] SYNC_BYTE    = 8'hA5
) (
    input  logic              i_Clock,
    input  logic              i_Reset,
    input  logic              i_Rx_DV,
    input  logic [7:0]        i_Rx_Byte,
    output logic              o_Frame_Valid,
    input  logic              i_Frame_Ready,
    output logic [7:0]        o_Frame_Id,
    output logic [ADDR_W:0]   o_Frame_Len,
    input  logic [ADDR_W-1:0] i_Rd_Addr,
    output logic [7:0]        o_Rd_Data,
    output logic              o_Err,
    output logic [1:0]        o_Err_Code,
    output logic [7:0]        o_Drop_Count
);

    localparam int MAX_LEN = 2**ADDR_W;
    localparam int TCNT_W  = $clog2(TIMEOUT_CLKS);
    localparam logic [TCNT_W-1:0] TCNT_LAST = TCNT_W'(TIMEOUT_CLKS - 1);

    localparam logic [1:0] ERR_LEN     = 2'd1;
    localparam logic [1:0] ERR_CHK     = 2'd2;
    localparam logic [1:0] ERR_TIMEOUT = 2'd3;

`ifdef UART_FRAME_CHECKSUM_EN
    typedef enum logic [2:0] {
        S_IDLE, S_ID, S_LEN, S_PAYLOAD, S_CHK, S_HOLD
    } state_t;
`else
    typedef enum logic [2:0] {
        S_IDLE, S_ID, S_LEN, S_PAYLOAD, S_HOLD
    } state_t;
`endif

    state_t              r_state;
    state_t              w_next_state;

    logic [7:0]          r_id;
    logic [ADDR_W:0]     r_len;
    logic [ADDR_W:0]     r_idx;
    logic [TCNT_W-1:0]   r_tcnt;
    logic                r_err;
    logic [1:0]          r_err_code;
    logic [7:0]          r_frame_id;
    logic [ADDR_W:0]     r_frame_len;
    logic [7:0]          r_drop_cnt;
    logic [7:0]          r_rd_data;
    logic [7:0]          r_mem [0:MAX_LEN-1];
`ifdef UART_FRAME_CHECKSUM_EN
    logic [7:0]          r_sum;
`endif

    logic                w_active;
    logic                w_timeout;
    logic                w_len_big;
    logic                w_last;
    logic                w_err;
    logic [1:0]          w_err_code;
    logic                w_hold_entry;
    logic                w_mem_we;
    logic                w_drop;

    // Timeout applies only while a frame is being parsed.
    assign w_active  = (r_state != S_IDLE) && (r_state != S_HOLD);
    assign w_timeout = w_active && !i_Rx_DV && (r_tcnt == TCNT_LAST);
    assign w_len_big = 32'(i_Rx_Byte) > MAX_LEN;
    assign w_last    = (r_idx == (r_len - 1'b1));

    // State register.
    always_ff @(posedge i_Clock or posedge i_Reset) begin
        if (i_Reset) r_state <= S_IDLE;
        else         r_state <= w_next_state;
    end

    // Next-state logic and per-cycle control strobes.
    always_comb begin
        w_next_state = r_state;
        w_err        = 1'b0;
        w_err_code   = 2'd0;
        w_hold_entry = 1'b0;
        w_mem_we     = 1'b0;
        w_drop       = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (i_Rx_DV && (i_Rx_Byte == SYNC_BYTE)) w_next_state = S_ID;
            end
            S_ID: begin
                if (i_Rx_DV) w_next_state = S_LEN;
            end
            S_LEN: begin
                if (i_Rx_DV) begin
                    if (w_len_big) begin
                        w_err        = 1'b1;
                        w_err_code   = ERR_LEN;
                        w_next_state = S_IDLE;
                    end else if (i_Rx_Byte == 8'd0) begin
`ifdef UART_FRAME_CHECKSUM_EN
                        w_next_state = S_CHK;
`else
                        w_next_state = S_HOLD;
                        w_hold_entry = 1'b1;
`endif
                    end else begin
                        w_next_state = S_PAYLOAD;
                    end
                end
            end
            S_PAYLOAD: begin
                if (i_Rx_DV) begin
                    w_mem_we = 1'b1;
                    if (w_last) begin
`ifdef UART_FRAME_CHECKSUM_EN
                        w_next_state = S_CHK;
`else
                        w_next_state = S_HOLD;
                        w_hold_entry = 1'b1;
`endif
                    end
                end
            end
`ifdef UART_FRAME_CHECKSUM_EN
            S_CHK: begin
                if (i_Rx_DV) begin
                    if (i_Rx_Byte == r_sum) begin
                        w_next_state = S_HOLD;
                        w_hold_entry = 1'b1;
                    end else begin
                        w_err        = 1'b1;
                        w_err_code   = ERR_CHK;
                        w_next_state = S_IDLE;
                    end
                end
            end
`endif
            S_HOLD: begin
                if (i_Rx_DV)       w_drop       = 1'b1;
                if (i_Frame_Ready) w_next_state = S_IDLE;
            end
            default: w_next_state = S_IDLE;
        endcase
        // A DV in the same cycle suppresses the timeout (w_timeout needs !DV).
        if (w_timeout) begin
            w_err        = 1'b1;
            w_err_code   = ERR_TIMEOUT;
            w_next_state = S_IDLE;
        end
    end

    // Header capture and payload index while parsing.
    always_ff @(posedge i_Clock or posedge i_Reset) begin
        if (i_Reset) begin
            r_id  <= 8'd0;
            r_len <= '0;
            r_idx <= '0;
        end else if (i_Rx_DV) begin
            case (r_state)
                S_ID:      r_id <= i_Rx_Byte;
                S_LEN: begin
                    r_len <= (ADDR_W+1)'(i_Rx_Byte);
                    r_idx <= '0;
                end
                S_PAYLOAD: r_idx <= r_idx + 1'b1;
                default: ;
            endcase
        end
    end

`ifdef UART_FRAME_CHECKSUM_EN
    // Running checksum: seeded by ID, accumulates LEN and payload.
    always_ff @(posedge i_Clock or posedge i_Reset) begin
        if (i_Reset) begin
            r_sum <= 8'd0;
        end else if (i_Rx_DV) begin
            case (r_state)
                S_ID:             r_sum <= i_Rx_Byte;
                S_LEN, S_PAYLOAD: r_sum <= r_sum + i_Rx_Byte;
                default: ;
            endcase
        end
    end
`endif

    // Inter-byte timeout counter: cleared by any DV or when idle/holding.
    always_ff @(posedge i_Clock or posedge i_Reset) begin
        if (i_Reset)                              r_tcnt <= '0;
        else if (!w_active || i_Rx_DV || w_timeout) r_tcnt <= '0;
        else                                      r_tcnt <= r_tcnt + 1'b1;
    end

    // Error pulse; the code is sticky until the next error.
    always_ff @(posedge i_Clock or posedge i_Reset) begin
        if (i_Reset) begin
            r_err      <= 1'b0;
            r_err_code <= 2'd0;
        end else begin
            r_err <= w_err;
            if (w_err) r_err_code <= w_err_code;
        end
    end

    // Published frame header, updated only when a frame enters HOLD.
    // A zero-length frame enters HOLD straight from LEN, before r_len loads.
    always_ff @(posedge i_Clock or posedge i_Reset) begin
        if (i_Reset) begin
            r_frame_id  <= 8'd0;
            r_frame_len <= '0;
        end else if (w_hold_entry) begin
            r_frame_id  <= r_id;
            r_frame_len <= (r_state == S_LEN) ? '0 : r_len;
        end
    end

    // Saturating count of bytes that arrive while a frame is held.
    always_ff @(posedge i_Clock or posedge i_Reset) begin
        if (i_Reset)                            r_drop_cnt <= 8'd0;
        else if (w_drop && r_drop_cnt != 8'hFF) r_drop_cnt <= r_drop_cnt + 1'b1;
    end

    // Payload buffer write port (contents are not reset).
    always_ff @(posedge i_Clock) begin
        if (w_mem_we) r_mem[r_idx[ADDR_W-1:0]] <= i_Rx_Byte;
    end

    // Registered read port; same-cycle write returns the old contents.
    always_ff @(posedge i_Clock or posedge i_Reset) begin
        if (i_Reset) r_rd_data <= 8'd0;
        else         r_rd_data <= r_mem[i_Rd_Addr];
    end

    assign o_Frame_Valid = (r_state == S_HOLD);
    assign o_Frame_Id    = r_frame_id;
    assign o_Frame_Len   = r_frame_len;
    assign o_Rd_Data     = r_rd_data;
    assign o_Err         = r_err;
    assign o_Err_Code    = r_err_code;
    assign o_Drop_Count  = r_drop_cnt;

endmodule

// File: tb/tb_uart_rx_frame_ctrl.sv
// Self-checking bench for uart_rx_frame_ctrl (ADDR_W=4, TIMEOUT_CLKS=100).
// The reference model works at frame level: it classifies each frame
// from its ID/LEN/payload/checksum and predicts the outcome, error code,
// held header, buffer contents and drop count.

module tb_uart_rx_frame_ctrl;

    localparam int         AW   = 4;
    localparam int         MAXL = 16;
    localparam int         TO   = 100;
    localparam logic [7:0] SYNC = 8'hA5;
`ifdef UART_FRAME_CHECKSUM_EN
    localparam bit CHK_EN = 1'b1;
`else
    localparam bit CHK_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic          dv;
    logic [7:0]    byt;
    logic          valid;
    logic          ready;
    logic [7:0]    fid;
    logic [AW:0]   flen;
    logic [AW-1:0] rd_addr;
    logic [7:0]    rd_data;
    logic          err;
    logic [1:0]    err_code;
    logic [7:0]    drop;

    int n_cmp = 0;
    int n_err = 0;
    int err_seen = 0;
    int err_exp  = 0;
    int drop_exp = 0;
    logic [7:0] pl [0:255];

    uart_rx_frame_ctrl #(.ADDR_W(AW), .TIMEOUT_CLKS(TO), .SYNC_BYTE(SYNC)) dut (
        .i_Clock(clk), .i_Reset(rst), .i_Rx_DV(dv), .i_Rx_Byte(byt),
        .o_Frame_Valid(valid), .i_Frame_Ready(ready), .o_Frame_Id(fid),
        .o_Frame_Len(flen), .i_Rd_Addr(rd_addr), .o_Rd_Data(rd_data),
        .o_Err(err), .o_Err_Code(err_code), .o_Drop_Count(drop)
    );

    always #5 clk = ~clk;

    // Count error pulses independently of the directed checks.
    always @(posedge clk) if (err === 1'b1) err_seen++;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One DV strobe, followed by one idle cycle; returns at the negedge
    // right after the edge that sampled the byte.
    task automatic send(input logic [7:0] b);
        @(negedge clk); dv = 1'b1; byt = b;
        @(negedge clk); dv = 1'b0;
    endtask

    task automatic note_drop();
        drop_exp = (drop_exp < 255) ? drop_exp + 1 : 255;
    endtask

    task automatic check_buffer(input int len, input string tag);
        for (int i = 0; i < len; i++) begin
            @(negedge clk); rd_addr = AW'(i);
            @(negedge clk); chk(tag, rd_data, pl[i]);
        end
    endtask

    task automatic accept();
        @(negedge clk); ready = 1'b1;
        @(negedge clk); ready = 1'b0;
        chk("valid_after_ready", valid, 0);
    endtask

    // Send one frame (payload taken from pl[]) and check the predicted outcome.
    // bad != 0 corrupts the checksum byte when checksums are built in.
    task automatic run_frame(input logic [7:0] id, input logic [7:0] len,
                             input logic [7:0] bad, input bit acc);
        logic [7:0] sum;
        int kind;
        sum = id + len;
        send(SYNC); send(id); send(len);
        if (len > MAXL) begin
            kind = 1;
        end else begin
            for (int i = 0; i < len; i++) begin
                send(pl[i]);
                sum = sum + pl[i];
            end
            if (CHK_EN) send(sum + bad);
            kind = (CHK_EN && bad != 8'd0) ? 2 : 0;
        end
        if (kind == 0) begin
            chk("valid", valid, 1);
            chk("frame_id", fid, id);
            chk("frame_len", flen, len);
            chk("no_err", err, 0);
            check_buffer(len, "rd_data");
            if (acc) accept();
        end else begin
            err_exp++;
            chk("err_pulse", err, 1);
            chk("err_code", err_code, kind);
            chk("no_valid", valid, 0);
            @(negedge clk);
            chk("err_one_cycle", err, 0);
        end
    endtask

    initial begin
        rst = 1'b1; dv = 1'b0; byt = 8'd0; ready = 1'b0; rd_addr = '0;
        repeat (2) @(negedge clk);
        chk("rst_valid", valid, 0);
        chk("rst_id", fid, 0);
        chk("rst_len", flen, 0);
        chk("rst_rd", rd_data, 0);
        chk("rst_err", err, 0);
        chk("rst_code", err_code, 0);
        chk("rst_drop", drop, 0);
        @(negedge clk); rst = 1'b0;

        // Good frame A5 03 02 11 22 (38)
        pl[0] = 8'h11; pl[1] = 8'h22;
        run_frame(8'h03, 8'h02, 8'h00, 1'b1);

        // Corrupted checksum (39), then garbage, then a good frame
        run_frame(8'h03, 8'h02, 8'h01, 1'b1);
        send(8'h00); send(8'hFF);
        chk("garbage_no_valid", valid, 0);
        pl[0] = 8'h5C; pl[1] = 8'h01; pl[2] = 8'hA5;
        run_frame(8'h42, 8'h03, 8'h00, 1'b1);

        // Oversized length, trailing bytes ignored until next sync
        run_frame(8'h07, 8'h11, 8'h00, 1'b1);
        send(8'h01); send(8'h02);
        chk("lenerr_ignored", valid, 0);

        // Timeout: error exactly TO edges after the ID byte
        send(SYNC); send(8'h09);
        repeat (TO - 1) @(negedge clk);
        chk("timeout_not_early", err, 0);
        @(negedge clk);
        err_exp++;
        chk("timeout_err", err, 1);
        chk("timeout_code", err_code, 3);
        @(negedge clk);
        chk("timeout_one_cycle", err, 0);

        // Zero-length frame
        run_frame(8'h09, 8'h00, 8'h00, 1'b1);

        // Hold drops: header and buffer must not change
        pl[0] = 8'hDE; pl[1] = 8'hAD; pl[2] = 8'hBE; pl[3] = 8'hEF;
        run_frame(8'h77, 8'h04, 8'h00, 1'b0);
        send(8'h5A); note_drop();
        send(SYNC);  note_drop();
        chk("drop_2", drop, drop_exp);
        chk("drop_valid", valid, 1);
        chk("drop_id", fid, 8'h77);
        chk("drop_len", flen, 4);
        check_buffer(4, "drop_buf");
        for (int i = 0; i < 300; i++) begin
            send(8'($urandom)); note_drop();
        end
        chk("drop_sat", drop, drop_exp);
        accept();

        // Randomized frames with interleaved idle-state garbage
        for (int f = 0; f < 24; f++) begin
            int typ;
            logic [7:0] len;
            logic [7:0] bad;
            int ng;
            ng = $urandom_range(0, 3);
            for (int g = 0; g < ng; g++) begin
                logic [7:0] gb;
                gb = 8'($urandom);
                if (gb == SYNC) gb = 8'h00;
                send(gb);
            end
            typ = $urandom_range(0, 3);
            len = (typ == 3) ? 8'($urandom_range(MAXL + 1, 255)) : 8'($urandom_range(0, MAXL));
            bad = (typ == 2) ? 8'($urandom_range(1, 255)) : 8'h00;
            for (int i = 0; i < MAXL; i++) pl[i] = 8'($urandom);
            run_frame(8'($urandom), len, bad, 1'b1);
        end

        // Reset mid-payload
        send(SYNC); send(8'h01); send(8'h04); send(8'hAA);
        @(negedge clk); rst = 1'b1;
        #1;
        chk("mid_rst_valid", valid, 0);
        chk("mid_rst_id", fid, 0);
        chk("mid_rst_len", flen, 0);
        chk("mid_rst_rd", rd_data, 0);
        chk("mid_rst_err", err, 0);
        chk("mid_rst_code", err_code, 0);
        chk("mid_rst_drop", drop, 0);
        drop_exp = 0;
        @(negedge clk); rst = 1'b0;
        pl[0] = 8'h10; pl[1] = 8'h20; pl[2] = 8'h30;
        run_frame(8'h01, 8'h03, 8'h00, 1'b1);
        chk("final_drop", drop, drop_exp);

        repeat (2) @(negedge clk);
        chk("err_pulse_total", err_seen, err_exp);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/uart_rx_frame_ctrl.md
# uart_rx_frame_ctrl

Frame controller that sits behind the UART receiver and consumes its byte stream (one-cycle data-valid strobe plus byte). It hunts for a sync byte, then parses ID, length, payload and checksum, and buffers the payload. A completed, verified frame is presented to the host logic through a valid/ready handshake and a random-access read port. Malformed, corrupted or stalled frames are discarded and reported as errors.

## Interface
- `ADDR_W`, default 4: payload buffer address width. Maximum payload is MAX_LEN = 2**ADDR_W bytes.
- `TIMEOUT_CLKS`, default 100000: inter-byte timeout in clocks while a frame is in progress. Must be ≥ 2.
- `SYNC_BYTE`, default 8'hA5: frame start marker.
- `i_Clock`  in  1  system clock, rising edge.
- `i_Reset`  in  1  asynchronous, active-high reset.
- `i_Rx_DV`  in  1  one-cycle strobe; `i_Rx_Byte` is valid this cycle.
- `i_Rx_Byte`  in  8  received byte.
- `o_Frame_Valid`  out  1  verified frame held in the buffer.
- `i_Frame_Ready`  in  1  host accepts the frame.
- `o_Frame_Id`  out  8  ID byte of the held frame.
- `o_Frame_Len`  out  ADDR_W+1  payload length of the held frame (0..MAX_LEN).
- `i_Rd_Addr`  in  ADDR_W  payload read address.
- `o_Rd_Data`  out  8  registered buffer read data.
- `o_Err`  out  1  one-cycle error pulse.
- `o_Err_Code`  out  2  error cause: 1 = length, 2 = checksum, 3 = timeout. Held until the next error.
- `o_Drop_Count`  out  8  saturating count of bytes dropped while in HOLD.

## Operation
- Frame format: SYNC, ID, LEN, LEN payload bytes, CHK.
- CHK equals the 8-bit sum modulo 256 of ID, LEN and all payload bytes.
- States:
  - IDLE: a DV byte equal to SYNC_BYTE → ID. Any other byte is ignored without error.
  - ID: on DV, latch the ID and seed the sum → LEN.
  - LEN: on DV, if the value > MAX_LEN → error code 1 and go to IDLE. If the value is 0 → CHK. Otherwise → PAYLOAD with the write index set to 0.
  - PAYLOAD: on DV, write the byte to buffer[index], increment index and add the byte to the sum. On the last byte → CHK.
  - CHK: on DV, if the byte matches the sum → HOLD. Otherwise → error code 2 and go to IDLE.
  - HOLD: `o_Frame_Valid` = 1. When `i_Frame_Ready` is high → IDLE. A DV byte in HOLD, including in the accept cycle, is dropped and increments `o_Drop_Count`, which saturates at 255.
- Timeout: the counter clears on every DV and counts in ID, LEN, PAYLOAD and CHK. If it reaches TIMEOUT_CLKS-1 without a DV → error code 3 and go to IDLE. If a DV and the timeout occur in the same cycle, the DV wins.
- `o_Frame_Id` and `o_Frame_Len` update only on entry to HOLD and stay stable until the next frame enters HOLD.
- Buffer contents are guaranteed only while in HOLD; a partially received frame may overwrite them after HOLD exits.
- The read port works in every state.

## Timing
- Reset values: state = IDLE, `o_Frame_Valid` = 0, `o_Frame_Id` = 0, `o_Frame_Len` = 0, `o_Rd_Data` = 0, `o_Err` = 0, `o_Err_Code` = 0, `o_Drop_Count` = 0, timeout counter = 0. The buffer is not reset.
- Each DV is processed on the edge where it is sampled; the state changes on that edge.
- `o_Frame_Valid` rises on the edge after the DV of the CHK byte (the last payload byte when the checksum is compiled out).
- `o_Frame_Valid` falls on the edge after the cycle where it is high together with `i_Frame_Ready`. Ready while valid is low has no effect.
- `o_Err` is high for exactly one cycle, starting on the edge after the offending DV or after the timeout cycle. `o_Err_Code` updates on the same edge.
- `o_Rd_Data` = buffer[`i_Rd_Addr`] with one cycle of latency. A read of an address in the same cycle it is written returns the old data.
- Asserting reset in any state, including mid-payload, returns the block to the reset values immediately, without waiting for a clock edge.

## Configuration
- `UART_FRAME_CHECKSUM_EN` defined: the CHK byte is present and verified as described above.
- `UART_FRAME_CHECKSUM_EN` undefined: there is no CHK state and no checksum byte.
  - The last payload byte goes directly to HOLD.
  - LEN = 0 goes directly to HOLD.
  - Error code 2 never occurs.
  - The sum logic is removed.

## Test plan
- Good frame: A5 03 02 11 22 38 → `o_Frame_Valid` = 1, `o_Frame_Id` = 0x03, `o_Frame_Len` = 2. Reading addr 0 → 0x11 and addr 1 → 0x22 (one cycle later). After ready, valid drops on the next cycle.
- Bad checksum: A5 03 02 11 22 39 → one `o_Err` pulse, `o_Err_Code` = 2, no valid. Then garbage 00 FF followed by a good frame → accepted.
- Length error (ADDR_W = 4): A5 07 11 → error code 1 after the LEN byte. The following bytes are ignored until the next A5.
- Timeout (TIMEOUT_CLKS = 100): A5 09, then silence → `o_Err` pulse with code 3 exactly 100 cycles after the ID DV. A zero-length frame A5 09 00 09 then succeeds.
- Hold drop: with valid held and ready low, send 2 bytes → `o_Drop_Count` = 2, ID/LEN/buffer unchanged. After 300 drops the count is 255.
- Reset mid-payload: A5 01 04 AA, then pulse reset → all outputs at reset values. A subsequent good frame completes normally.
